// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared constants and state encoding for the score accumulator slice.
//   SCORE_DIGITS  : number of BCD digits held in the score
//   SCORE_MAX_BCD : saturation value of the BCD score
//   COUNT_W       : width of the hit / miss totals
//   COMBO_W       : width of the consecutive-hit counter
//   acc_state_t   : IDLE (nothing queued) / SERVE (events pending)
// ---------------------------------------------------------------------------
package score_pkg;

    localparam int          SCORE_DIGITS  = 4;
    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;
    localparam int          COUNT_W       = 10;
    localparam int          COMBO_W       = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } acc_state_t;

endpackage

// File: rtl/score_accumulator_if.sv
// ---------------------------------------------------------------------------
// score_accumulator_if
// Bundles the lane event levels coming from the pattern instances, the
// game-over freeze, and the scoreboard outputs consumed by placar.
//   freeze   : game over, discards pending and new events
//   ponto    : per-lane hit level
//   trocar   : per-lane note-advance level
//   display  : {multiplier BCD, 4-digit BCD score}
//   hits     : saturating hit total
//   misses   : saturating miss total
//   busy     : events still queued
// master = event/producer side, slave = the accumulator.
// ---------------------------------------------------------------------------
interface score_accumulator_if #(
    parameter int N_LANES = 4
);
    import score_pkg::*;

    logic               freeze;
    logic [N_LANES-1:0] ponto;
    logic [N_LANES-1:0] trocar;
    logic [19:0]        display;
    logic [COUNT_W-1:0] hits;
    logic [COUNT_W-1:0] misses;
    logic               busy;

    modport master (
        output freeze, ponto, trocar,
        input  display, hits, misses, busy
    );

    modport slave (
        input  freeze, ponto, trocar,
        output display, hits, misses, busy
    );

endinterface

// File: rtl/bcd_sat_add4.sv
// ---------------------------------------------------------------------------
// bcd_sat_add4
// Combinational 4-digit BCD adder with a single-digit addend. A carry out
// of the most significant digit means the true sum exceeds 9999, so the
// result pins at 9999 instead of wrapping.
//   bcd_in  : 16-bit BCD operand
//   addend  : 0..9, added to the least significant digit
//   bcd_sum : saturated 16-bit BCD result
// ---------------------------------------------------------------------------
module bcd_sat_add4
    import score_pkg::*;
(
    input  logic [15:0] bcd_in,
    input  logic [3:0]  addend,
    output logic [15:0] bcd_sum
);

    logic [15:0] raw_sum;
    logic        carry;
    logic [4:0]  digit_sum;

    // Ripple the decimal carry digit by digit, starting with the addend.
    always_comb begin
        raw_sum   = '0;
        carry     = 1'b0;
        digit_sum = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (d == 0) begin
                digit_sum = {1'b0, bcd_in[3:0]} + {1'b0, addend};
            end else begin
                digit_sum = {1'b0, bcd_in[d*4 +: 4]} + {4'b0000, carry};
            end
            if (digit_sum > 5'd9) begin
                raw_sum[d*4 +: 4] = 4'(digit_sum - 5'd10);
                carry             = 1'b1;
            end else begin
                raw_sum[d*4 +: 4] = digit_sum[3:0];
                carry             = 1'b0;
            end
        end
        bcd_sum = carry ? SCORE_MAX_BCD : raw_sum;
    end

endmodule

// File: rtl/score_accumulator.sv
// ---------------------------------------------------------------------------
// score_accumulator
// Receives per-lane hit (ponto) and note-advance (trocar) levels, turns
// their rising edges into queued hit/miss events and serves one event per
// CLOCK_25 cycle, lowest lane first, hits before misses. Keeps a combo
// counter and multiplier, a saturating BCD score and hit/miss totals.
//   CLOCK_25 : system clock
//   reset    : synchronous, active-high, clears all state
//   bus      : slave side of score_accumulator_if (events in, scoreboard out)
// ---------------------------------------------------------------------------
module score_accumulator
    import score_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int COMBO_STEP = 8,
    parameter int MAX_MULT   = 4
)(
    input  logic                CLOCK_25,
    input  logic                reset,
    score_accumulator_if.slave  bus
);

    acc_state_t         state_q, state_d;

    logic [N_LANES-1:0] prev_ponto_q, prev_trocar_q;
    logic [N_LANES-1:0] hit_flag_q, hit_flag_d;
    logic [N_LANES-1:0] hit_pend_q, hit_pend_d;
    logic [N_LANES-1:0] miss_pend_q, miss_pend_d;

    logic [15:0]        score_q;
    logic [15:0]        score_sum;
    logic [3:0]         mult_q, mult_next;
    logic [COMBO_W-1:0] combo_q, combo_inc;
    logic [COUNT_W-1:0] hits_q, misses_q;

    logic [N_LANES-1:0] rise_p, rise_t;
    logic [N_LANES-1:0] hit_cap, miss_cap;
    logic [N_LANES-1:0] hit_sel, miss_sel;
    logic               serve_hit, serve_miss;
    logic               found;
    int                 mult_calc;

    bcd_sat_add4 u_add (
        .bcd_in  (score_q),
        .addend  (mult_q),
        .bcd_sum (score_sum)
    );

    // State register.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Edge detection, capture, arbitration and next state. Service only
    // looks at already-registered pending bits, so a freshly captured
    // event is never served on its capture edge. A rise on a lane whose
    // pending bit was already set is absorbed, even if that bit is being
    // served on the same edge.
    always_comb begin
        rise_p = bus.ponto  & ~prev_ponto_q;
        rise_t = bus.trocar & ~prev_trocar_q;

        hit_cap  = '0;
        miss_cap = '0;
        hit_flag_d = hit_flag_q;
        if (!bus.freeze) begin
            hit_cap    = rise_p;
            miss_cap   = rise_t & ~hit_flag_q & ~rise_p;
            hit_flag_d = (hit_flag_q | rise_p) & ~rise_t;
        end

        hit_sel  = '0;
        miss_sel = '0;
        found    = 1'b0;
        if (state_q == SERVE && !bus.freeze) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (hit_pend_q[i] && !found) begin
                    hit_sel[i] = 1'b1;
                    found      = 1'b1;
                end
            end
            for (int i = 0; i < N_LANES; i++) begin
                if (miss_pend_q[i] && !found) begin
                    miss_sel[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
        serve_hit  = |hit_sel;
        serve_miss = |miss_sel;

        if (bus.freeze) begin
            hit_pend_d  = '0;
            miss_pend_d = '0;
        end else begin
            hit_pend_d  = (hit_pend_q  & ~hit_sel)  | (hit_cap  & ~hit_pend_q);
            miss_pend_d = (miss_pend_q & ~miss_sel) | (miss_cap & ~miss_pend_q);
        end

        state_d = (|{hit_pend_d, miss_pend_d}) ? SERVE : IDLE;

        combo_inc = (combo_q == '1) ? combo_q : combo_q + 1'b1;
        mult_calc = 1 + int'(combo_inc) / COMBO_STEP;
        if (mult_calc > MAX_MULT) begin
            mult_calc = MAX_MULT;
        end
        mult_next = 4'(mult_calc);
    end

    // Event capture and scoring datapath. The point value added on a hit
    // is the multiplier before this hit's combo increment.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            prev_ponto_q  <= '0;
            prev_trocar_q <= '0;
            hit_flag_q    <= '0;
            hit_pend_q    <= '0;
            miss_pend_q   <= '0;
            score_q       <= '0;
            mult_q        <= 4'd1;
            combo_q       <= '0;
            hits_q        <= '0;
            misses_q      <= '0;
        end else begin
            prev_ponto_q  <= bus.ponto;
            prev_trocar_q <= bus.trocar;
            hit_flag_q    <= hit_flag_d;
            hit_pend_q    <= hit_pend_d;
            miss_pend_q   <= miss_pend_d;
            if (serve_hit) begin
                score_q <= score_sum;
                combo_q <= combo_inc;
                mult_q  <= mult_next;
                if (hits_q != '1) begin
                    hits_q <= hits_q + 1'b1;
                end
            end else if (serve_miss) begin
                combo_q <= '0;
                mult_q  <= 4'd1;
                if (misses_q != '1) begin
                    misses_q <= misses_q + 1'b1;
                end
            end
        end
    end

    assign bus.display = {mult_q, score_q};
    assign bus.hits    = hits_q;
    assign bus.misses  = misses_q;
    assign bus.busy    = (state_q == SERVE);

endmodule

// File: tb/tb_score_accumulator.sv
// ---------------------------------------------------------------------------
// tb_score_accumulator
// Directed scenarios plus a randomized run of score_accumulator, checked
// against a behavioural scoreboard model that keeps the score as a plain
// integer and the queued events as per-lane sets.
// ---------------------------------------------------------------------------
module tb_score_accumulator;

    localparam int N_LANES    = 4;
    localparam int COMBO_STEP = 8;
    localparam int MAX_MULT   = 4;

    logic CLOCK_25 = 1'b0;
    logic reset;

    score_accumulator_if #(.N_LANES(N_LANES)) bus ();

    score_accumulator #(
        .N_LANES    (N_LANES),
        .COMBO_STEP (COMBO_STEP),
        .MAX_MULT   (MAX_MULT)
    ) dut (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .bus      (bus)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_score, m_combo, m_mult, m_hits, m_misses;
    logic [3:0] m_prev_p, m_prev_t, m_flag, m_hpend, m_mpend;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [19:0] exp_display();
        return {4'(m_mult), to_bcd(m_score)};
    endfunction

    // Model of one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        logic [3:0] rp, rt, old_h, old_m;
        bit         served;
        if (reset) begin
            m_score = 0; m_combo = 0; m_mult = 1; m_hits = 0; m_misses = 0;
            m_prev_p = '0; m_prev_t = '0; m_flag = '0; m_hpend = '0; m_mpend = '0;
            return;
        end
        rp = bus.ponto & ~m_prev_p;
        rt = bus.trocar & ~m_prev_t;
        m_prev_p = bus.ponto;
        m_prev_t = bus.trocar;
        if (bus.freeze) begin
            m_hpend = '0;
            m_mpend = '0;
            return;
        end
        old_h  = m_hpend;
        old_m  = m_mpend;
        served = 0;
        for (int l = 0; l < N_LANES; l++) begin
            if (!served && old_h[l]) begin
                served = 1;
                m_hpend[l] = 1'b0;
                m_score = (m_score + m_mult > 9999) ? 9999 : m_score + m_mult;
                m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
                m_hits  = (m_hits >= 1023) ? 1023 : m_hits + 1;
                m_mult  = 1 + m_combo / COMBO_STEP;
                if (m_mult > MAX_MULT) m_mult = MAX_MULT;
            end
        end
        for (int l = 0; l < N_LANES; l++) begin
            if (!served && old_m[l]) begin
                served = 1;
                m_mpend[l] = 1'b0;
                m_combo  = 0;
                m_mult   = 1;
                m_misses = (m_misses >= 1023) ? 1023 : m_misses + 1;
            end
        end
        for (int l = 0; l < N_LANES; l++) begin
            if (rp[l] && !old_h[l]) m_hpend[l] = 1'b1;
            if (rt[l] && !rp[l] && !m_flag[l] && !old_m[l]) m_mpend[l] = 1'b1;
            if (rt[l]) m_flag[l] = 1'b0;
            else if (rp[l]) m_flag[l] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge CLOCK_25);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ponto = '0;
        bus.trocar = '0;
        bus.freeze = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_hit(int lane);
        bus.ponto[lane] = 1'b1;
        step();
        bus.ponto[lane] = 1'b0;
        step();
    endtask

    task automatic pulse_miss(int lane);
        bus.trocar[lane] = 1'b1;
        step();
        bus.trocar[lane] = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        if (bus.display !== 20'h10000) begin errors++; $display("[TB] FAIL reset_display got %h expected %h", bus.display, 20'h10000); end
        checks++;
        if (bus.hits !== 10'd0 || bus.misses !== 10'd0) begin errors++; $display("[TB] FAIL reset_counts got hits=%0d misses=%0d expected 0/0", bus.hits, bus.misses); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", bus.busy); end
        checks++;
        step();
        if (bus.display !== 20'h10000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset got display=%h busy=%b expected 10000/0", bus.display, bus.busy); end
        checks++;
    endtask

    task automatic test_single_hit();
        int busy_cycles = 0;
        do_reset();
        bus.ponto[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) bus.ponto[0] = 1'b0;
            step();
            if (bus.busy === 1'b1) busy_cycles++;
            if (c == 1 && bus.display !== 20'h10000) begin errors++; $display("[TB] FAIL single_capture got %h expected %h", bus.display, 20'h10000); end
            if (c == 2 && bus.display !== 20'h10001) begin errors++; $display("[TB] FAIL single_score got %h expected %h", bus.display, 20'h10001); end
            if (c <= 2) checks++;
        end
        if (bus.hits !== 10'd1) begin errors++; $display("[TB] FAIL single_hits got %0d expected 1", bus.hits); end
        checks++;
        if (busy_cycles != 1) begin errors++; $display("[TB] FAIL single_busy got %0d cycles expected 1", busy_cycles); end
        checks++;
    endtask

    task automatic test_simultaneous();
        int busy_cycles = 0;
        do_reset();
        bus.ponto = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            step();
            bus.ponto = 4'h0;
            if (bus.busy === 1'b1) busy_cycles++;
            if (k <= 5) begin
                if (bus.display[15:0] !== 16'(k - 1)) begin errors++; $display("[TB] FAIL simul_score step %0d got %h expected %h", k, bus.display[15:0], 16'(k - 1)); end
                checks++;
            end
        end
        if (busy_cycles != 4) begin errors++; $display("[TB] FAIL simul_busy got %0d cycles expected 4", busy_cycles); end
        checks++;
    endtask

    task automatic test_combo();
        int exp_m;
        do_reset();
        for (int h = 1; h <= 20; h++) begin
            pulse_hit(1);
            exp_m = (h >= 16) ? 3 : (h >= 8) ? 2 : 1;
            if (bus.display[19:16] !== 4'(exp_m)) begin errors++; $display("[TB] FAIL combo_mult hit %0d got %0d expected %0d", h, bus.display[19:16], exp_m); end
            checks++;
        end
        if (bus.display !== 20'h30036) begin errors++; $display("[TB] FAIL combo_final got %h expected %h", bus.display, 20'h30036); end
        checks++;
    endtask

    task automatic test_miss();
        do_reset();
        for (int h = 0; h < 9; h++) pulse_hit(0);
        if (bus.display !== 20'h20010) begin errors++; $display("[TB] FAIL miss_pre got %h expected %h", bus.display, 20'h20010); end
        checks++;
        pulse_miss(2);
        if (bus.display !== 20'h10010 || bus.misses !== 10'd1) begin errors++; $display("[TB] FAIL miss_served got display=%h misses=%0d expected 10010/1", bus.display, bus.misses); end
        checks++;
        bus.ponto[2] = 1'b1;
        bus.trocar[2] = 1'b1;
        step();
        bus.ponto[2] = 1'b0;
        bus.trocar[2] = 1'b0;
        step();
        step();
        if (bus.display !== 20'h10011 || bus.hits !== 10'd10 || bus.misses !== 10'd1) begin
            errors++;
            $display("[TB] FAIL miss_same_cycle got display=%h hits=%0d misses=%0d expected 10011/10/1", bus.display, bus.hits, bus.misses);
        end
        checks++;
    endtask

    task automatic test_saturation();
        do_reset();
        pulse_hit(0);
        pulse_hit(0);
        pulse_miss(3);
        for (int h = 0; h < 24; h++) pulse_hit(0);
        if (bus.display !== 20'h40050) begin errors++; $display("[TB] FAIL sat_ramp got %h expected %h", bus.display, 20'h40050); end
        checks++;
        for (int h = 0; h < 2487; h++) pulse_hit(0);
        if (bus.display !== 20'h49998) begin errors++; $display("[TB] FAIL sat_preload got %h expected %h", bus.display, 20'h49998); end
        checks++;
        pulse_hit(0);
        if (bus.display !== 20'h49999) begin errors++; $display("[TB] FAIL sat_clamp got %h expected %h", bus.display, 20'h49999); end
        checks++;
        pulse_hit(0);
        if (bus.display !== 20'h49999 || bus.hits !== 10'd1023) begin errors++; $display("[TB] FAIL sat_hold got display=%h hits=%0d expected 49999/1023", bus.display, bus.hits); end
        checks++;
    endtask

    task automatic test_freeze_and_reset();
        do_reset();
        bus.ponto = 4'b0111;
        step();
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL freeze_pending got busy=%b expected 1", bus.busy); end
        checks++;
        bus.freeze = 1'b1;
        step();
        if (bus.busy !== 1'b0 || bus.display !== 20'h10000 || bus.hits !== 10'd0) begin
            errors++;
            $display("[TB] FAIL freeze_clear got busy=%b display=%h hits=%0d expected 0/10000/0", bus.busy, bus.display, bus.hits);
        end
        checks++;
        bus.ponto = 4'b0000;
        step();
        bus.ponto = 4'b1000;
        step();
        step();
        if (bus.busy !== 1'b0 || bus.hits !== 10'd0) begin errors++; $display("[TB] FAIL freeze_ignore got busy=%b hits=%0d expected 0/0", bus.busy, bus.hits); end
        checks++;
        bus.freeze = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.busy !== 1'b0 || bus.hits !== 10'd0) begin errors++; $display("[TB] FAIL unfreeze_spurious cycle %0d got busy=%b hits=%0d expected 0/0", c, bus.busy, bus.hits); end
            checks++;
        end
        bus.ponto = 4'b0000;
        step();
        bus.ponto = 4'hF;
        step();
        bus.ponto = 4'h0;
        step();
        if (bus.display !== 20'h10001 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midserve got display=%h busy=%b expected 10001/1", bus.display, bus.busy); end
        checks++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if (bus.display !== 20'h10000 || bus.busy !== 1'b0 || bus.hits !== 10'd0) begin
            errors++;
            $display("[TB] FAIL midserve_reset got display=%h busy=%b hits=%0d expected 10000/0/0", bus.display, bus.busy, bus.hits);
        end
        checks++;
        step();
        if (bus.display !== 20'h10000 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL after_reset got display=%h busy=%b expected 10000/0", bus.display, bus.busy); end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.ponto  = 4'($urandom_range(0, 15));
            bus.trocar = 4'($urandom_range(0, 15));
            bus.freeze = ($urandom_range(0, 29) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            step();
            if (bus.display !== exp_display()) begin errors++; $display("[TB] FAIL rand_display cycle %0d got %h expected %h", c, bus.display, exp_display()); end
            checks++;
            if (bus.hits !== 10'(m_hits) || bus.misses !== 10'(m_misses)) begin
                errors++;
                $display("[TB] FAIL rand_counts cycle %0d got %0d/%0d expected %0d/%0d", c, bus.hits, bus.misses, m_hits, m_misses);
            end
            checks++;
            if (bus.busy !== (|{m_hpend, m_mpend})) begin errors++; $display("[TB] FAIL rand_busy cycle %0d got %b expected %b", c, bus.busy, |{m_hpend, m_mpend}); end
            checks++;
        end
        reset = 1'b0;
        bus.freeze = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.ponto = '0;
        bus.trocar = '0;
        bus.freeze = 1'b0;
        $display("[TB] starting score_accumulator bench");
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_combo();
        test_miss();
        test_saturation();
        test_freeze_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_accumulator.md
Name: score_accumulator

Overview:
- Receiving end of the per-lane hit/advance event interface driven by the pattern instances (ponto = note hit, trocar = note left the lane / request next command).
- Replaces the top-level ripple counter clocked on ponto. Edge-detects events in the CLOCK_25 domain and queues simultaneous events. Serves one event per cycle.
- Maintains a combo counter and multiplier, a saturating BCD score, and hit/miss totals. Drives the 20-bit display bus consumed by placar.

Parameters:
- N_LANES, 4, number of pattern instances feeding events (1..8).
- COMBO_STEP, 8, consecutive hits per multiplier increment.
- MAX_MULT, 4, multiplier ceiling (1..9).

Ports:
- CLOCK_25  in  1  pixel/system clock; the only clock.
- reset  in  1  synchronous, active-high; clears all state.
- freeze  in  1  game over (fim_de_jogo); while high, new rising edges are ignored and pending events are discarded.
- ponto  in  N_LANES  per-lane hit level from each pattern.
- trocar  in  N_LANES  per-lane note-advance level from each pattern.
- display  out  20  [15:0] score in 4 BCD digits, [19:16] current multiplier in BCD.
- hits  out  10  total hits, binary, saturating at 1023.
- misses  out  10  total misses, binary, saturating at 1023.
- busy  out  1  high while any pending bit is set.

Behaviour:
- Reset, and the first cycle after reset: display = 20'h10000 (score 0000, multiplier 1); hits = 0; misses = 0; busy = 0; pending, hit_flag and prev registers = 0.
- Edge detect: prev_ponto and prev_trocar are registered every cycle. rise_p = ponto & ~prev_ponto; rise_t = trocar & ~prev_trocar. prev registers load the live inputs even while freeze is high, so deasserting freeze creates no spurious edge.
- Per-lane hit_flag:
  - set on rise_p;
  - cleared on rise_t;
  - if rise_p and rise_t occur in the same cycle, the lane counts a hit and hit_flag ends at 0.
- Queueing: on the edge where rise_p[i] is captured, hit_pend[i] is set. On rise_t[i] with hit_flag[i]=0 and rise_p[i]=0, miss_pend[i] is set. A new rise on a lane whose pending bit is still set is absorbed (at most one queued event per lane per type).
- Service: one event per clock, on the edge after capture (latency 1 cycle from the capturing edge to the visible score change). Priority: lowest-index hit_pend first, then lowest-index miss_pend. The served bit is cleared on the same edge. A pending bit set and served on the same edge is not allowed; capture always wins over clear for a different lane.
- Hit service:
  - score_bcd += mult (BCD add with carry across 4 digits), saturating at 9999;
  - combo += 1, saturating at 255;
  - hits += 1, saturating;
  - mult = min(1 + combo_new / COMBO_STEP, MAX_MULT), and mult updates after the add. The point value uses the pre-increment multiplier.
- Miss service: combo = 0; mult = 1; misses += 1, saturating; score unchanged.
- State machine: IDLE (no pending) -> SERVE (any pending; busy = 1) -> IDLE when the last pending bit clears. freeze high forces IDLE and clears all pending bits on the same edge. The score and counters hold their values.
- Reset mid-service: the synchronous reset dominates all other updates on that edge.

Decomposition:
- Package score_pkg holds SCORE_DIGITS = 4, SCORE_MAX_BCD = 16'h9999, COUNT_W = 10, COMBO_W = 8, and the IDLE/SERVE state encoding.
- Sub-module bcd_sat_add4 is combinational. Inputs: 16-bit BCD and a 4-bit addend (0..9). Outputs: 16-bit BCD sum, saturating at 9999.
- The arbiter is a lowest-index priority encoder kept inline.

Test Plan:
- Reset, then a single ponto[0] pulse of 3 cycles -> exactly one hit; display = 16'h0001 in low bits one cycle after capture; hits = 1; busy high for exactly 1 cycle.
- ponto[0..3] all rise on the same cycle -> four services on consecutive cycles, lane 0 first; final score 0004; busy high for 4 cycles.
- 20 sequential single-lane hits with COMBO_STEP = 8 -> mult steps 1→2 after the 8th hit and 2→3 after the 16th. Final score 8·1 + 8·2 + 4·3 = 36 (display low = 16'h0036, high nibble 3).
- trocar[2] rises with no prior ponto[2] -> misses = 1, combo 0, display[19:16] = 1, score unchanged. Then ponto[2] and trocar[2] rise on the same cycle -> a hit is counted and no miss is recorded.
- Preload to 9998 with mult 4 (via a hit sequence), then one hit -> score saturates at 9999 with no wrap to 0000.
- freeze asserted while 3 hits are pending -> pending cleared and busy = 0 on the next edge; score frozen. ponto edges while frozen are ignored. Deasserting freeze with ponto held high creates no hit. A reset pulse mid-SERVE returns display to 20'h10000.
